// File: rtl/elite_i2c_reg_slave_if.sv
// Bus-side signal bundle for the oversampled I2C register slave: raw I2C pins
// towards the board buffer and the strobe interface towards the register file.
interface elite_i2c_reg_slave_if #(
    parameter int REG_AW = 7
);
    logic              I2C_SCL;
    logic              I2C_SDA_In;
    logic              I2C_SDA_OE;
    logic [REG_AW-1:0] Reg_Addr;
    logic [7:0]        Reg_WData;
    logic              Reg_Wr;
    logic              Reg_Rd;
    logic [7:0]        Reg_RData;
    logic              Busy;
    logic              Data_Ready_Flag;

    modport slave (
        input  I2C_SCL, I2C_SDA_In, Reg_RData,
        output I2C_SDA_OE, Reg_Addr, Reg_WData, Reg_Wr, Reg_Rd, Busy, Data_Ready_Flag
    );

    modport master (
        output I2C_SCL, I2C_SDA_In, Reg_RData,
        input  I2C_SDA_OE, Reg_Addr, Reg_WData, Reg_Wr, Reg_Rd, Busy, Data_Ready_Flag
    );
endinterface

// File: rtl/elite_i2c_reg_slave.sv
// Fully MClk-synchronous I2C register slave. SCL/SDA are synchronised and
// glitch-filtered, bus events become single-cycle pulses, and a byte-level FSM
// handles device addressing, pointer load, multi-byte writes/reads with
// optional pointer auto-increment, repeated START and STOP.
module elite_i2c_reg_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int          REG_AW   = 7,
    parameter int          FILT_LEN = 4,
    parameter int          AUTO_INC = 1
) (
    input logic                  MClk,
    input logic                  I2C_Rst_N,
    elite_i2c_reg_slave_if.slave bus
);
    localparam int CW = $clog2(FILT_LEN) + 1;

    typedef enum logic [3:0] {
        IDLE, DEVA, ACKD, PTR, ACKP, WDAT, ACKW, RDAT, MACK, WAIT
    } state_t;

    // Index 1 carries SCL, index 0 carries SDA through the conditioning chain.
    logic [1:0]    sync1, sync2, filt, filt_d;
    logic [CW-1:0] filt_cnt [2];

    logic scl_f, sda_f, scl_rise, scl_fall, sda_rise, sda_fall;
    logic start_evt, stop_evt;

    state_t            state, state_n;
    logic [3:0]        bit_cnt, bit_cnt_n;
    logic [6:0]        shift, shift_n;
    logic [6:0]        tx, tx_n;
    logic              oe, oe_n;
    logic [REG_AW-1:0] ptr, ptr_n;
    logic [7:0]        wdata, wdata_n;
    logic              wr, wr_n;
    logic              rd, rd_n;
    logic              busy, busy_n;
    logic              rw, rw_n;
    logic              mack, mack_n;
    logic [7:0]        byte_in;

    // Two-stage synchroniser followed by a level filter that only changes after
    // FILT_LEN consecutive identical samples disagree with the current level.
    always_ff @(posedge MClk) begin
        if (!I2C_Rst_N) begin
            sync1       <= 2'b11;
            sync2       <= 2'b11;
            filt        <= 2'b11;
            filt_d      <= 2'b11;
            filt_cnt[0] <= '0;
            filt_cnt[1] <= '0;
        end else begin
            sync1  <= {bus.I2C_SCL, bus.I2C_SDA_In};
            sync2  <= sync1;
            filt_d <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != filt[i]) begin
                    if (filt_cnt[i] == CW'(FILT_LEN - 1)) begin
                        filt[i]     <= sync2[i];
                        filt_cnt[i] <= '0;
                    end else begin
                        filt_cnt[i] <= filt_cnt[i] + CW'(1);
                    end
                end else begin
                    filt_cnt[i] <= '0;
                end
            end
        end
    end

    assign scl_f     = filt[1];
    assign sda_f     = filt[0];
    assign scl_rise  = filt[1] & ~filt_d[1];
    assign scl_fall  = ~filt[1] & filt_d[1];
    assign sda_rise  = filt[0] & ~filt_d[0];
    assign sda_fall  = ~filt[0] & filt_d[0];
    assign start_evt = sda_fall & scl_f;
    assign stop_evt  = sda_rise & scl_f;
    assign byte_in   = {shift, sda_f};

    // State and datapath register; reset releases SDA and drops any partial byte.
    always_ff @(posedge MClk) begin
        if (!I2C_Rst_N) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= '0;
            oe      <= 1'b0;
            ptr     <= '0;
            wdata   <= '0;
            wr      <= 1'b0;
            rd      <= 1'b0;
            busy    <= 1'b0;
            rw      <= 1'b0;
            mack    <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            shift   <= shift_n;
            tx      <= tx_n;
            oe      <= oe_n;
            ptr     <= ptr_n;
            wdata   <= wdata_n;
            wr      <= wr_n;
            rd      <= rd_n;
            busy    <= busy_n;
            rw      <= rw_n;
            mack    <= mack_n;
        end
    end

    // Next-state logic: START/STOP take priority over any bit sample in the same
    // cycle; strobes from the previous cycle finish their pointer/data side effects.
    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        tx_n      = tx;
        oe_n      = oe;
        ptr_n     = ptr;
        wdata_n   = wdata;
        wr_n      = 1'b0;
        rd_n      = 1'b0;
        busy_n    = busy;
        rw_n      = rw;
        mack_n    = mack;

        if (wr && (AUTO_INC != 0)) begin
            ptr_n = ptr + REG_AW'(1);
        end
        if (rd) begin
            tx_n = bus.Reg_RData[6:0];
            oe_n = ~bus.Reg_RData[7];
        end

        if (start_evt) begin
            state_n   = DEVA;
            bit_cnt_n = '0;
            oe_n      = 1'b0;
        end else if (stop_evt) begin
            state_n   = IDLE;
            bit_cnt_n = '0;
            oe_n      = 1'b0;
            busy_n    = 1'b0;
        end else begin
            case (state)
                DEVA, PTR, WDAT: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shift_n   = byte_in[6:0];
                        bit_cnt_n = bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            if (state == DEVA) begin
                                if (byte_in[7:1] == DEV_ADDR) begin
                                    rw_n   = byte_in[0];
                                    busy_n = 1'b1;
                                end else begin
                                    state_n   = IDLE;
                                    bit_cnt_n = '0;
                                    busy_n    = 1'b0;
                                end
                            end else if (state == PTR) begin
                                ptr_n = byte_in[REG_AW-1:0];
                            end else begin
                                wr_n    = 1'b1;
                                wdata_n = byte_in;
                            end
                        end
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_n = '0;
                        oe_n      = 1'b1;
                        if (state == DEVA)     state_n = ACKD;
                        else if (state == PTR) state_n = ACKP;
                        else                   state_n = ACKW;
                    end
                end
                ACKD: begin
                    if (scl_fall) begin
                        oe_n      = 1'b0;
                        bit_cnt_n = '0;
                        if (rw) begin
                            rd_n    = 1'b1;
                            state_n = RDAT;
                        end else begin
                            state_n = PTR;
                        end
                    end
                end
                ACKP, ACKW: begin
                    if (scl_fall) begin
                        oe_n      = 1'b0;
                        bit_cnt_n = '0;
                        state_n   = WDAT;
                    end
                end
                RDAT: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt != 4'd0) begin
                        if (bit_cnt == 4'd8) begin
                            oe_n      = 1'b0;
                            bit_cnt_n = '0;
                            mack_n    = 1'b0;
                            state_n   = MACK;
                            if (AUTO_INC != 0) begin
                                ptr_n = ptr + REG_AW'(1);
                            end
                        end else begin
                            oe_n = ~tx[6];
                            tx_n = {tx[5:0], 1'b0};
                        end
                    end
                end
                MACK: begin
                    if (scl_rise) begin
                        if (!sda_f) begin
                            mack_n = 1'b1;
                        end else begin
                            oe_n    = 1'b0;
                            busy_n  = 1'b0;
                            state_n = WAIT;
                        end
                    end else if (scl_fall && mack) begin
                        mack_n    = 1'b0;
                        rd_n      = 1'b1;
                        bit_cnt_n = '0;
                        state_n   = RDAT;
                    end
                end
                WAIT: begin
                    oe_n = 1'b0;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign bus.I2C_SDA_OE      = oe;
    assign bus.Reg_Addr        = ptr;
    assign bus.Reg_WData       = wdata;
    assign bus.Reg_Wr          = wr;
    assign bus.Reg_Rd          = rd;
    assign bus.Busy            = busy;
    assign bus.Data_Ready_Flag = wr;
endmodule

// File: tb/tb_elite_i2c_reg_slave.sv
// Directed bench for elite_i2c_reg_slave. Two slaves share one open-drain bus:
// A at 0x50 with auto-increment, B at 0x51 with the pointer held. The bench
// acts as I2C master and models the register file as data = addr + 0x80.
module tb_elite_i2c_reg_slave;
    localparam int Q = 10;

    logic mclk    = 1'b0;
    logic rst_n   = 1'b0;
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;
    logic sda_line;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [15:0] wa_q[$];
    logic [15:0] wb_q[$];
    int rd_cnt_a  = 0;
    int rd_cnt_b  = 0;
    int drf_cnt_a = 0;
    int oe_cnt    = 0;

    always #10 mclk = ~mclk;

    elite_i2c_reg_slave_if #(.REG_AW(7)) a_if ();
    elite_i2c_reg_slave_if #(.REG_AW(7)) b_if ();

    assign sda_line        = sda_drv & ~a_if.I2C_SDA_OE & ~b_if.I2C_SDA_OE;
    assign a_if.I2C_SCL    = scl_drv;
    assign b_if.I2C_SCL    = scl_drv;
    assign a_if.I2C_SDA_In = sda_line;
    assign b_if.I2C_SDA_In = sda_line;
    assign a_if.Reg_RData  = {1'b0, a_if.Reg_Addr} + 8'h80;
    assign b_if.Reg_RData  = {1'b0, b_if.Reg_Addr} + 8'h80;

    elite_i2c_reg_slave #(.DEV_ADDR(7'h50), .REG_AW(7), .FILT_LEN(4), .AUTO_INC(1)) dut_a (
        .MClk      (mclk),
        .I2C_Rst_N (rst_n),
        .bus       (a_if)
    );

    elite_i2c_reg_slave #(.DEV_ADDR(7'h51), .REG_AW(7), .FILT_LEN(4), .AUTO_INC(0)) dut_b (
        .MClk      (mclk),
        .I2C_Rst_N (rst_n),
        .bus       (b_if)
    );

    // Record register-file strobes and any SDA drive from either slave.
    always @(negedge mclk) begin
        if (a_if.Reg_Wr) wa_q.push_back({1'b0, a_if.Reg_Addr, a_if.Reg_WData});
        if (b_if.Reg_Wr) wb_q.push_back({1'b0, b_if.Reg_Addr, b_if.Reg_WData});
        if (a_if.Reg_Rd) rd_cnt_a++;
        if (b_if.Reg_Rd) rd_cnt_b++;
        if (a_if.Data_Ready_Flag) drf_cnt_a++;
        if (a_if.I2C_SDA_OE || b_if.I2C_SDA_OE) oe_cnt++;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge mclk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wait_cyc(Q);
        scl_drv = 1'b1; wait_cyc(Q);
        sda_drv = 1'b0; wait_cyc(Q);
        scl_drv = 1'b0; wait_cyc(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; wait_cyc(Q);
        scl_drv = 1'b1; wait_cyc(Q);
        sda_drv = 1'b1; wait_cyc(2 * Q);
    endtask

    task automatic send_bit(input logic b, input logic glitch);
        sda_drv = b;
        if (glitch) begin
            wait_cyc(3);
            scl_drv = 1'b1; wait_cyc(1);
            scl_drv = 1'b0; wait_cyc(Q - 4);
        end else begin
            wait_cyc(Q);
        end
        scl_drv = 1'b1; wait_cyc(2 * Q);
        scl_drv = 1'b0; wait_cyc(Q);
    endtask

    task automatic read_bit(output logic v);
        sda_drv = 1'b1; wait_cyc(Q);
        scl_drv = 1'b1; wait_cyc(Q);
        v = sda_line;   wait_cyc(Q);
        scl_drv = 1'b0; wait_cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack_n);
        for (int i = 7; i >= 0; i--) send_bit(b[i], (i == glitch_bit));
        read_bit(ack_n);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) read_bit(d[i]);
        send_bit(nack, 1'b0);
    endtask

    initial begin
        logic       ack_n;
        logic       v;
        logic [7:0] d;
        int rd0, oe0, wr0, rdall0;

        // Reset state
        wait_cyc(5);
        check_output("rst_oe",   {31'd0, a_if.I2C_SDA_OE}, 32'd0);
        check_output("rst_addr", {25'd0, a_if.Reg_Addr},   32'd0);
        check_output("rst_wr",   {31'd0, a_if.Reg_Wr},     32'd0);
        check_output("rst_rd",   {31'd0, a_if.Reg_Rd},     32'd0);
        check_output("rst_busy", {31'd0, a_if.Busy},       32'd0);
        check_output("rst_drf",  {31'd0, a_if.Data_Ready_Flag}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(20);

        // 1: multi-byte write with auto-increment
        i2c_start();
        write_byte(8'hA0, -1, ack_n); check_output("t1_ack_dev", {31'd0, ack_n}, 32'd0);
        check_output("t1_busy", {31'd0, a_if.Busy}, 32'd1);
        write_byte(8'h05, -1, ack_n); check_output("t1_ack_ptr", {31'd0, ack_n}, 32'd0);
        write_byte(8'h3C, -1, ack_n); check_output("t1_ack_d0",  {31'd0, ack_n}, 32'd0);
        write_byte(8'h7E, -1, ack_n); check_output("t1_ack_d1",  {31'd0, ack_n}, 32'd0);
        i2c_stop();
        check_output("t1_wr_cnt", wa_q.size(), 32'd2);
        check_output("t1_wr0", {16'd0, wa_q[0]}, 32'h053C);
        check_output("t1_wr1", {16'd0, wa_q[1]}, 32'h067E);
        check_output("t1_drf_cnt", drf_cnt_a, 32'd2);
        check_output("t1_busy_end", {31'd0, a_if.Busy}, 32'd0);

        // 2: pointer write, repeated START, 3-byte read
        rd0 = rd_cnt_a;
        i2c_start();
        write_byte(8'hA0, -1, ack_n);
        write_byte(8'h10, -1, ack_n);
        i2c_start();
        write_byte(8'hA1, -1, ack_n); check_output("t2_ack_rd", {31'd0, ack_n}, 32'd0);
        read_byte(1'b0, d); check_output("t2_rd0", {24'd0, d}, 32'h90);
        read_byte(1'b0, d); check_output("t2_rd1", {24'd0, d}, 32'h91);
        read_byte(1'b1, d); check_output("t2_rd2", {24'd0, d}, 32'h92);
        check_output("t2_oe_nack",   {31'd0, a_if.I2C_SDA_OE}, 32'd0);
        check_output("t2_busy_nack", {31'd0, a_if.Busy}, 32'd0);
        i2c_stop();
        check_output("t2_rd_cnt", rd_cnt_a - rd0, 32'd3);

        // 3: address mismatch stays silent
        oe0    = oe_cnt;
        wr0    = wa_q.size() + wb_q.size();
        rdall0 = rd_cnt_a + rd_cnt_b;
        i2c_start();
        write_byte(8'hB0, -1, ack_n); check_output("t3_nack_dev", {31'd0, ack_n}, 32'd1);
        write_byte(8'h01, -1, ack_n);
        write_byte(8'hFF, -1, ack_n);
        i2c_stop();
        check_output("t3_oe_cnt", oe_cnt - oe0, 32'd0);
        check_output("t3_wr_cnt", wa_q.size() + wb_q.size() - wr0, 32'd0);
        check_output("t3_rd_cnt", rd_cnt_a + rd_cnt_b - rdall0, 32'd0);

        // 4: pointer wrap on A, pointer hold on B
        i2c_start();
        write_byte(8'hA0, -1, ack_n);
        write_byte(8'h7F, -1, ack_n);
        write_byte(8'h11, -1, ack_n);
        write_byte(8'h22, -1, ack_n);
        i2c_stop();
        check_output("t4_wrap0", {16'd0, wa_q[2]}, 32'h7F11);
        check_output("t4_wrap1", {16'd0, wa_q[3]}, 32'h0022);
        i2c_start();
        write_byte(8'hA2, -1, ack_n); check_output("t4_b_ack", {31'd0, ack_n}, 32'd0);
        write_byte(8'h7F, -1, ack_n);
        write_byte(8'h33, -1, ack_n);
        write_byte(8'h44, -1, ack_n);
        i2c_stop();
        check_output("t4_hold_cnt", wb_q.size(), 32'd2);
        check_output("t4_hold0", {16'd0, wb_q[0]}, 32'h7F33);
        check_output("t4_hold1", {16'd0, wb_q[1]}, 32'h7F44);

        // 5a: one-cycle SCL glitch inside a data byte is ignored
        i2c_start();
        write_byte(8'hA0, -1, ack_n);
        write_byte(8'h30, -1, ack_n);
        write_byte(8'h5A, 3, ack_n); check_output("t5_glitch_ack", {31'd0, ack_n}, 32'd0);
        i2c_stop();
        check_output("t5_glitch_wr", {16'd0, wa_q[4]}, 32'h305A);

        // 5b: STOP after 4 data bits discards the partial byte
        i2c_start();
        write_byte(8'hA0, -1, ack_n);
        write_byte(8'h20, -1, ack_n);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        i2c_stop();
        check_output("t5_abort_wr",   wa_q.size(), 32'd5);
        check_output("t5_abort_busy", {31'd0, a_if.Busy}, 32'd0);
        check_output("t5_abort_oe",   {31'd0, a_if.I2C_SDA_OE}, 32'd0);

        // 5c: reset while driving a read bit releases SDA on the next MClk
        i2c_start();
        write_byte(8'hA0, -1, ack_n);
        write_byte(8'h00, -1, ack_n);
        i2c_start();
        write_byte(8'hA1, -1, ack_n);
        read_bit(v); check_output("t5_rd_bit7", {31'd0, v}, 32'd1);
        check_output("t5_rd_drive", {31'd0, a_if.I2C_SDA_OE}, 32'd1);
        rst_n = 1'b0;
        wait_cyc(1);
        check_output("t5_rst_oe",   {31'd0, a_if.I2C_SDA_OE}, 32'd0);
        check_output("t5_rst_busy", {31'd0, a_if.Busy}, 32'd0);
        check_output("t5_rst_addr", {25'd0, a_if.Reg_Addr}, 32'd0);
        wait_cyc(3);
        rst_n   = 1'b1;
        scl_drv = 1'b1;
        sda_drv = 1'b1;
        wait_cyc(4 * Q);

        // 5d: normal operation resumes after the abort
        i2c_start();
        write_byte(8'hA0, -1, ack_n); check_output("t5_recover_ack", {31'd0, ack_n}, 32'd0);
        write_byte(8'h01, -1, ack_n);
        write_byte(8'h55, -1, ack_n);
        i2c_stop();
        check_output("t5_recover_wr", {16'd0, wa_q[5]}, 32'h0155);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
